// File: rtl/wb_initiator_seq.sv
// Wishbone classic single-transaction initiator: one command in, one bus cycle,
// one response out. A bounded ack wait turns a silent slave into an error response.
module wb_initiator_seq #(
    parameter int ADR_W   = 32,
    parameter int DAT_W   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_ni,
    input  logic               cmd_valid_i,
    output logic               cmd_ready_o,
    input  logic               cmd_we_i,
    input  logic [ADR_W-1:0]   cmd_adr_i,
    input  logic [DAT_W-1:0]   cmd_dat_i,
    input  logic [DAT_W/8-1:0] cmd_sel_i,
    output logic               rsp_valid_o,
    input  logic               rsp_ready_i,
    output logic [DAT_W-1:0]   rsp_dat_o,
    output logic               rsp_err_o,
    output logic               busy_o,
    output logic               wbm_cyc_o,
    output logic               wbm_stb_o,
    output logic               wbm_we_o,
    output logic [ADR_W-1:0]   wbm_adr_o,
    output logic [DAT_W-1:0]   wbm_dat_o,
    output logic [DAT_W/8-1:0] wbm_sel_o,
    input  logic               wbm_ack_i,
    input  logic [DAT_W-1:0]   wbm_dat_i
);

    localparam int CNT_W     = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam int TO_LAST_I = (TIMEOUT < 1) ? 0 : TIMEOUT - 1;
    localparam logic [CNT_W-1:0] TO_LAST = TO_LAST_I[CNT_W-1:0];

    // Handshakes: a command transfers on a rising edge where cmd_valid_i & cmd_ready_o,
    // a response where rsp_valid_o & rsp_ready_i; both sides hold their payload until then.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             timeout_hit;

    // Counter holds the number of completed BUS cycles without ack.
    assign timeout_hit = (TIMEOUT != 0) && (cnt == TO_LAST);
    assign cmd_ready_o = (state == IDLE) & wb_rst_ni;
    assign busy_o      = (state != IDLE);

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state       <= IDLE;
            cnt         <= '0;
            wbm_cyc_o   <= 1'b0;
            wbm_stb_o   <= 1'b0;
            wbm_we_o    <= 1'b0;
            wbm_adr_o   <= '0;
            wbm_dat_o   <= '0;
            wbm_sel_o   <= '0;
            rsp_valid_o <= 1'b0;
            rsp_dat_o   <= '0;
            rsp_err_o   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid_i) begin
                        state     <= BUS;
                        cnt       <= '0;
                        wbm_cyc_o <= 1'b1;
                        wbm_stb_o <= 1'b1;
                        wbm_we_o  <= cmd_we_i;
                        wbm_adr_o <= cmd_adr_i;
                        wbm_dat_o <= cmd_dat_i;
                        wbm_sel_o <= cmd_sel_i;
                    end
                end
                BUS: begin
                    // Ack is checked first so a late ack still beats the timeout.
                    if (wbm_ack_i) begin
                        state       <= RESP;
                        wbm_cyc_o   <= 1'b0;
                        wbm_stb_o   <= 1'b0;
                        rsp_valid_o <= 1'b1;
                        rsp_err_o   <= 1'b0;
                        rsp_dat_o   <= wbm_we_o ? '0 : wbm_dat_i;
                    end else if (timeout_hit) begin
                        state       <= RESP;
                        wbm_cyc_o   <= 1'b0;
                        wbm_stb_o   <= 1'b0;
                        rsp_valid_o <= 1'b1;
                        rsp_err_o   <= 1'b1;
                        rsp_dat_o   <= '0;
                    end else if (cnt != {CNT_W{1'b1}}) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        state       <= IDLE;
                        rsp_valid_o <= 1'b0;
                        rsp_err_o   <= 1'b0;
                        rsp_dat_o   <= '0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    wbm_cyc_o   <= 1'b0;
                    wbm_stb_o   <= 1'b0;
                    rsp_valid_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_initiator_seq.sv
// Bench for wb_initiator_seq: vector table, randomized transactions against a
// transaction-level model, and hand-written timing corner cases.
module tb_wb_initiator_seq;

    localparam int TO8 = 8;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid, cmd_we;
    logic [31:0] cmd_adr, cmd_dat;
    logic [3:0]  cmd_sel;
    logic        rsp_ready, ack;
    logic [31:0] slv_dat;
    logic        cmd_ready, rsp_valid, rsp_err, busy, cyc, stb, we;
    logic [31:0] rsp_dat, adr, dat;
    logic [3:0]  sel;

    logic        cmd_valid4, rsp_ready4, ack4;
    logic        cmd_ready4, rsp_valid4, rsp_err4, busy4, cyc4, stb4, we4;
    logic [31:0] rsp_dat4, adr4, dat4;
    logic [3:0]  sel4;

    int n_tests = 0;
    int n_fail  = 0;

    wb_initiator_seq #(.ADR_W(32), .DAT_W(32), .TIMEOUT(TO8)) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
        .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat), .cmd_sel_i(cmd_sel),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_dat_o(rsp_dat),
        .rsp_err_o(rsp_err), .busy_o(busy),
        .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_adr_o(adr),
        .wbm_dat_o(dat), .wbm_sel_o(sel), .wbm_ack_i(ack), .wbm_dat_i(slv_dat)
    );

    wb_initiator_seq #(.ADR_W(32), .DAT_W(32), .TIMEOUT(4)) dut4 (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .cmd_valid_i(cmd_valid4), .cmd_ready_o(cmd_ready4), .cmd_we_i(cmd_we),
        .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat), .cmd_sel_i(cmd_sel),
        .rsp_valid_o(rsp_valid4), .rsp_ready_i(rsp_ready4), .rsp_dat_o(rsp_dat4),
        .rsp_err_o(rsp_err4), .busy_o(busy4),
        .wbm_cyc_o(cyc4), .wbm_stb_o(stb4), .wbm_we_o(we4), .wbm_adr_o(adr4),
        .wbm_dat_o(dat4), .wbm_sel_o(sel4), .wbm_ack_i(ack4), .wbm_dat_i(slv_dat)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Transaction-level reference: the slave acks after `delay` wait cycles unless
    // the TIMEOUT window of stb-high cycles closes first.
    task automatic ref_model(input logic we_i, input int delay, input logic [31:0] sdat,
                             output logic err, output logic [31:0] rdat, output int nstb);
        if (delay < TO8) begin
            err  = 1'b0;
            rdat = we_i ? 32'h0 : sdat;
            nstb = delay + 1;
        end else begin
            err  = 1'b1;
            rdat = 32'h0;
            nstb = TO8;
        end
    endtask

    // Driver + slave for dut: issues one command, acks on stb cycle `delay`,
    // holds rsp_ready low for `hold` cycles, then checks the response.
    task automatic run_txn(input string tag, input logic we_i, input logic [31:0] adr_i,
                           input logic [31:0] dat_i, input logic [3:0] sel_i, input int delay,
                           input logic [31:0] sdat, input int hold, input logic exp_err,
                           input logic [31:0] exp_dat, input int exp_stb);
        int guard;
        int nstb;
        guard = 0;
        while (!cmd_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        check({tag, "_cmd_ready"}, cmd_ready, 1'b1);
        cmd_valid = 1'b1; cmd_we = we_i; cmd_adr = adr_i; cmd_dat = dat_i; cmd_sel = sel_i;
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_adr = $urandom; cmd_dat = $urandom; cmd_sel = 4'($urandom);
        check({tag, "_cyc_after_accept"}, {cyc, busy, cmd_ready}, 3'b110);
        nstb = 0;
        while (cyc && nstb < 64) begin
            check({tag, "_wbm_stable"}, {stb, we, adr, dat, sel}, {1'b1, we_i, adr_i, dat_i, sel_i});
            if (nstb == delay) begin
                ack = 1'b1; slv_dat = sdat;
            end else begin
                ack = 1'b0; slv_dat = $urandom;
            end
            @(posedge clk); #1;
            ack = 1'b0;
            nstb++;
        end
        check({tag, "_stb_cycles"}, 128'(nstb), 128'(exp_stb));
        for (int i = 0; i < hold; i++) begin
            check({tag, "_held"}, {rsp_valid, rsp_err, rsp_dat, cmd_ready, cyc},
                  {1'b1, exp_err, exp_dat, 1'b0, 1'b0});
            ack = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        ack = 1'b0;
        check({tag, "_rsp"}, {rsp_valid, rsp_err, rsp_dat}, {1'b1, exp_err, exp_dat});
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check({tag, "_after_hs"}, {rsp_valid, busy, cmd_ready}, 3'b001);
    endtask

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        int          delay;
        logic [31:0] sdat;
        int          hold;
        logic        exp_err;
        logic [31:0] exp_dat;
        int          exp_stb;
    } vec_t;

    vec_t vecs[6];

    initial begin : watchdog
        #200000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : main
        logic        m_err;
        logic [31:0] m_dat;
        int          m_stb;
        int          n;
        logic        r_we;
        logic [31:0] r_adr, r_dat, r_sdat;
        logic [3:0]  r_sel;
        int          r_delay, r_hold;

        vecs[0] = '{1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF, 0, 32'h1111_1111, 0, 1'b0, 32'h0, 1};
        vecs[1] = '{1'b0, 32'h3000_0008, 32'h0, 4'hF, 2, 32'h1234_5678, 0, 1'b0, 32'h1234_5678, 3};
        vecs[2] = '{1'b0, 32'h3000_000C, 32'h0, 4'h3, 30, 32'h5555_5555, 0, 1'b1, 32'h0, 8};
        vecs[3] = '{1'b0, 32'h3000_0010, 32'h0, 4'hC, 7, 32'hCAFE_F00D, 0, 1'b0, 32'hCAFE_F00D, 8};
        vecs[4] = '{1'b1, 32'h3000_0014, 32'h0BAD_F00D, 4'h1, 8, 32'h7777_7777, 0, 1'b1, 32'h0, 8};
        vecs[5] = '{1'b0, 32'h3000_0018, 32'h0, 4'hF, 1, 32'h0BAD_C0DE, 5, 1'b0, 32'h0BAD_C0DE, 2};

        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
        rsp_ready = 1'b0; ack = 1'b0; slv_dat = '0;
        cmd_valid4 = 1'b0; rsp_ready4 = 1'b0; ack4 = 1'b0;
        #3;
        check("reset_outputs", {cyc, stb, we, adr, dat, sel, rsp_valid, rsp_dat, rsp_err, busy, cmd_ready},
              '0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_ready", {cmd_ready, busy, cyc, rsp_valid}, 4'b1000);

        // Table-driven vectors
        for (int i = 0; i < 6; i++)
            run_txn($sformatf("vec%0d", i), vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel,
                    vecs[i].delay, vecs[i].sdat, vecs[i].hold, vecs[i].exp_err,
                    vecs[i].exp_dat, vecs[i].exp_stb);

        // Backpressure: a waiting command is taken only the cycle after the handshake
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h3000_0020; cmd_dat = 32'h0102_0304; cmd_sel = 4'hF;
        @(posedge clk); #1;
        ack = 1'b1; cmd_adr = 32'h3000_0024; cmd_we = 1'b0;
        @(posedge clk); #1;
        ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("bp_hold", {rsp_valid, rsp_err, rsp_dat, cmd_ready, cyc}, {1'b1, 1'b0, 32'h0, 1'b0, 1'b0});
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("bp_after_hs", {rsp_valid, cyc, cmd_ready}, 3'b001);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("bp_next_accept", {cyc, stb, we, adr}, {1'b1, 1'b1, 1'b0, 32'h3000_0024});
        ack = 1'b1; slv_dat = 32'h4433_2211;
        @(posedge clk); #1;
        ack = 1'b0;
        check("bp_next_rsp", {rsp_valid, rsp_err, rsp_dat}, {1'b1, 1'b0, 32'h4433_2211});
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;

        // Ack/timeout collision on the TIMEOUT=4 instance
        cmd_valid4 = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h3000_0040; cmd_sel = 4'hF;
        @(posedge clk); #1;
        cmd_valid4 = 1'b0;
        n = 0;
        while (cyc4 && n < 20) begin
            check("col_stb", {stb4, adr4}, {1'b1, 32'h3000_0040});
            ack4 = (n == 3);
            slv_dat = (n == 3) ? 32'hA5A5_A5A5 : 32'h0;
            @(posedge clk); #1;
            ack4 = 1'b0;
            n++;
        end
        check("col_stb_cycles", 128'(n), 128'(4));
        check("col_rsp", {rsp_valid4, rsp_err4, rsp_dat4}, {1'b1, 1'b0, 32'hA5A5_A5A5});
        rsp_ready4 = 1'b1;
        @(posedge clk); #1;
        rsp_ready4 = 1'b0;
        check("col_idle", {rsp_valid4, cmd_ready4}, 2'b01);

        // Randomized transactions against the reference model
        for (int i = 0; i < 40; i++) begin
            r_we    = 1'($urandom_range(0, 1));
            r_adr   = $urandom;
            r_dat   = $urandom;
            r_sel   = 4'($urandom_range(0, 15));
            r_delay = $urandom_range(0, 11);
            r_sdat  = $urandom;
            r_hold  = $urandom_range(0, 3);
            ref_model(r_we, r_delay, r_sdat, m_err, m_dat, m_stb);
            run_txn("rnd", r_we, r_adr, r_dat, r_sel, r_delay, r_sdat, r_hold, m_err, m_dat, m_stb);
        end

        // Asynchronous reset in the middle of a bus cycle
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h3000_0080;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check("rst_pre_bus", {cyc, stb}, 2'b11);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_drop", {cyc, stb, busy, cmd_ready, rsp_valid}, 5'b00000);
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("rst_release", {rsp_valid, cmd_ready, cyc, busy}, 4'b0100);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_initiator_seq.md
Name: wb_initiator_seq

Overview:
- Wishbone classic single-transaction initiator (bus master).
- Drives a Wishbone slave port of the user_proj_example kind, either on chip or across a bench boundary.
- A simple valid/ready command interface in; a valid/ready response interface out.
- Bounded ack timeout, so a silent or missing slave cannot hang the requester.

Parameters:
ADR_W, 32, address width
DAT_W, 32, data width; SEL width = DAT_W/8
TIMEOUT, 255, max cycles waiting for ack in BUS; 0 = no timeout

Ports:
wb_clk_i  input  1  clock, all logic rising-edge
wb_rst_ni  input  1  asynchronous active-low reset
cmd_valid_i  input  1  command offered
cmd_ready_o  output  1  command accepted when cmd_valid_i & cmd_ready_o
cmd_we_i  input  1  1 = write, 0 = read
cmd_adr_i  input  ADR_W  byte address
cmd_dat_i  input  DAT_W  write data
cmd_sel_i  input  DAT_W/8  byte enables
rsp_valid_o  output  1  response available
rsp_ready_i  input  1  response consumed when rsp_valid_o & rsp_ready_i
rsp_dat_o  output  DAT_W  read data; 0 for writes and errors
rsp_err_o  output  1  1 = timeout
busy_o  output  1  high whenever state != IDLE
wbm_cyc_o  output  1  Wishbone cycle
wbm_stb_o  output  1  Wishbone strobe
wbm_we_o  output  1  Wishbone write enable
wbm_adr_o  output  ADR_W  Wishbone address
wbm_dat_o  output  DAT_W  Wishbone write data
wbm_sel_o  output  DAT_W/8  Wishbone byte select
wbm_ack_i  input  1  slave acknowledge
wbm_dat_i  input  DAT_W  slave read data

Behaviour:
- Clock and reset: one clock, wb_clk_i. wb_rst_ni is asynchronous and active-low. Deassertion is synchronised externally.
- Reset values: state=IDLE; wbm_cyc_o=wbm_stb_o=wbm_we_o=0; wbm_adr_o=wbm_dat_o=wbm_sel_o=0; rsp_valid_o=0; rsp_dat_o=0; rsp_err_o=0; busy_o=0; timeout counter=0.
- cmd_ready_o = (state==IDLE) & wb_rst_ni. It is combinational from state and does not depend on cmd_valid_i.
- FSM states: IDLE, BUS, RESP.
- IDLE -> BUS on command accept:
  - register we/adr/dat/sel into the wbm_* outputs;
  - assert wbm_cyc_o and wbm_stb_o from the next cycle;
  - clear the counter.
- In BUS, all wbm_* outputs stay stable until the cycle ends.
- BUS, wbm_ack_i sampled 1 -> RESP:
  - next cycle: wbm_cyc_o=wbm_stb_o=0, rsp_valid_o=1, rsp_err_o=0;
  - rsp_dat_o = wbm_dat_i for reads (sampled in the ack cycle), 0 for writes.
- BUS, no ack:
  - counter increments each cycle;
  - when counter==TIMEOUT-1 and ack is still low -> RESP with rsp_err_o=1, rsp_dat_o=0, cyc/stb dropped;
  - a read times out after exactly TIMEOUT cycles of stb high;
  - if ack and timeout occur in the same cycle, ack wins (err=0).
- TIMEOUT=0: never times out. The counter saturates and is unused.
- RESP: rsp_valid_o and rsp_dat_o/rsp_err_o are held stable until rsp_ready_i=1, then -> IDLE. A command can be accepted the cycle after the handshake.
- Minimum latency: accept in cycle 0, cyc/stb high in cycle 1, ack in cycle 1, rsp_valid_o in cycle 2. Back-to-back throughput is one transaction per 3 cycles with immediate ack and rsp_ready_i held 1.
- wbm_ack_i outside BUS is ignored. wbm_cyc_o is never held across transactions (no block/RMW cycles). Only one transaction is outstanding.
- Reset mid-operation: cyc/stb drop immediately (asynchronously). Any pending response is discarded. After release the block is in IDLE.
- Counter width = clog2(TIMEOUT+1), minimum 1 bit.

Test Plan:
- Write with immediate ack: cmd_we=1, adr=0x3000_0004, dat=0xDEAD_BEEF, sel=0xF -> cyc/stb/we high for 1 cycle with those values; rsp_valid in cycle 2 with err=0 and dat=0.
- Read with 3-cycle wait: slave acks on the 3rd stb cycle with 0x1234_5678 -> wbm outputs stable for all 3 cycles; rsp_dat=0x1234_5678, err=0.
- Timeout: TIMEOUT=8, no ack -> stb high exactly 8 cycles, then rsp_err=1, rsp_dat=0, cyc=0.
- Backpressure: rsp_ready=0 for 5 cycles after a response -> rsp_valid and data held; cmd_ready=0; a new cmd_valid is not accepted until 1 cycle after the handshake.
- Ack/timeout collision: TIMEOUT=4, ack on the 4th cycle with 0xA5A5_A5A5 -> err=0, dat=0xA5A5_A5A5.
- Async reset mid-BUS: drop wb_rst_ni between clock edges -> cyc/stb go 0 without a clock edge; no rsp_valid after release; cmd_ready=1.
